// File: rtl/dcfifo_arb_pkg.sv
// Shared types and the rotate-priority search used by the FIFO write-port arbiter.
package dcfifo_arb_pkg;

  localparam int MAX_REQ = 16;
  localparam int IDXW    = 4;

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} arb_state_e;

  typedef struct packed {
    logic        found;
    logic [31:0] idx;
  } rr_res_t;

  // First set bit of valid at or after ptr, wrapping modulo n.
  function automatic rr_res_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                      input logic [IDXW-1:0]    ptr,
                                      input int                 n);
    rr_res_t res;
    int      j;
    res = '0;
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      if (k < n) begin
        j = int'(ptr) + k;
        if (j >= n) j = j - n;
        if (valid[j[IDXW-1:0]]) begin
          res.found = 1'b1;
          res.idx   = j;
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/dcfifo_rr_pick.sv
// Combinational rotate-priority encoder: picks the next requester from ptr upward.
module dcfifo_rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         valid,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);
  import dcfifo_arb_pkg::*;

  rr_res_t res;

  always_comb begin
    res = rr_pick(MAX_REQ'(valid), IDXW'(ptr), N);
    idx = ($clog2(N))'(res.idx);
    any = res.found;
  end

endmodule

// File: rtl/dcfifo_wr_arbiter.sv
// Round-robin burst arbiter for the write port of a dual-clock FIFO; only grants
// a burst when the FIFO has room for a full burst plus wrusedw latency slack.
module dcfifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 64,
  parameter int WIDTHU    = 9,
  parameter int MAX_BURST = 8,
  parameter int SLACK     = 4
) (
  input  logic                         wrclk,
  input  logic                         aclr_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]     req_data,
  input  logic [NUM_REQ-1:0]           req_last,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [WIDTH-1:0]             fifo_data,
  output logic                         fifo_wrreq,
  input  logic                         fifo_wrfull,
  input  logic [WIDTHU-1:0]            fifo_wrusedw,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         busy,
  output logic                         ovf_err
);
  import dcfifo_arb_pkg::*;

  localparam int IW   = $clog2(NUM_REQ);
  localparam int CW   = $clog2(MAX_BURST + 1);
  localparam int NEED = MAX_BURST + SLACK;

  arb_state_e        state_q, state_d;
  logic [IW-1:0]     grant_q, grant_d, rr_ptr_q, rr_ptr_d, pick_idx;
  logic [CW-1:0]     beat_cnt_q, beat_cnt_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic              wrreq_q, ovf_q, pick_any;
  logic [WIDTHU:0]   free;
  logic              admit, beat, burst_end;

  dcfifo_rr_pick #(.N(NUM_REQ)) u_pick (
    .valid (req_valid),
    .ptr   (rr_ptr_q),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign free      = {1'b0, {WIDTHU{1'b1}}} - {1'b0, fifo_wrusedw};
  assign admit     = (32'(free) >= NEED) && !fifo_wrfull && pick_any;
  assign beat      = (state_q == BURST) && req_valid[grant_q] && !fifo_wrfull;
  // last and max-count on the same beat collapse into one end event
  assign burst_end = beat && (req_last[grant_q] || (beat_cnt_q + 1'b1 == CW'(MAX_BURST)));

  always_ff @(posedge wrclk or negedge aclr_n) begin
    if (!aclr_n) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (admit)     state_d = BURST;
      BURST: if (burst_end) state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    busy      = (state_q == BURST);
    if (state_q == BURST) req_ready[grant_q] = !fifo_wrfull;
  end

  always_comb begin
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    data_d     = data_q;
    if (state_q == IDLE && admit) begin
      grant_d    = pick_idx;
      beat_cnt_d = '0;
    end
    if (beat) begin
      beat_cnt_d = beat_cnt_q + 1'b1;
      data_d     = req_data[grant_q*WIDTH +: WIDTH];
    end
    if (burst_end) rr_ptr_d = (grant_q == IW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
  end

  always_ff @(posedge wrclk or negedge aclr_n) begin
    if (!aclr_n) begin
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      data_q     <= '0;
      wrreq_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      data_q     <= data_d;
      wrreq_q    <= beat;
      ovf_q      <= ovf_q | (wrreq_q & fifo_wrfull);
    end
  end

  assign fifo_data  = data_q;
  assign fifo_wrreq = wrreq_q;
  assign grant_id   = grant_q;
  assign ovf_err    = ovf_q;

endmodule
